// File: rtl/cpu_state_dumper.sv
// Captures a CPU state snapshot on a trigger and streams it out as a 13-byte
// frame (header, pc, instr, R0..R7, XOR checksum) over a valid/ready byte port.
module cpu_state_dumper #(
    parameter logic [7:0] HEADER = 8'hA5,
    parameter int         NREG   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [7:0]        pc,
    input  logic [15:0]       instr,
    input  logic [8*NREG-1:0] regs_flat,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drop_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd12;
    localparam logic [7:0] DROP_MAX = 8'hFF;

    state_t              state_q, state_d;
    logic [3:0]          idx_q, idx_d;
    logic [7:0]          pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [8*NREG-1:0]   regs_q, regs_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                accept_s;

    // XOR of header, pc, both instruction bytes and every register byte.
    function automatic logic [7:0] frame_checksum(
        input logic [7:0]        f_pc,
        input logic [15:0]       f_instr,
        input logic [8*NREG-1:0] f_regs
    );
        logic [7:0] c;
        c = HEADER ^ f_pc ^ f_instr[15:8] ^ f_instr[7:0];
        for (int k = 0; k < NREG; k++) begin
            c = c ^ f_regs[8*k +: 8];
        end
        return c;
    endfunction

    // Byte offered at a given frame index; index 13 is reserved and reads as zero.
    function automatic logic [7:0] frame_byte(
        input logic [3:0]        f_idx,
        input logic [7:0]        f_pc,
        input logic [15:0]       f_instr,
        input logic [8*NREG-1:0] f_regs,
        input logic [7:0]        f_csum
    );
        logic [7:0] b;
        case (f_idx)
            4'd0:    b = HEADER;
            4'd1:    b = f_pc;
            4'd2:    b = f_instr[15:8];
            4'd3:    b = f_instr[7:0];
            4'd4:    b = f_regs[7:0];
            4'd5:    b = f_regs[15:8];
            4'd6:    b = f_regs[23:16];
            4'd7:    b = f_regs[31:24];
            4'd8:    b = f_regs[39:32];
            4'd9:    b = f_regs[47:40];
            4'd10:   b = f_regs[55:48];
            4'd11:   b = f_regs[63:56];
            4'd12:   b = f_csum;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept_s = tx_valid_q & tx_ready;

    // Next-state logic: frame sequencing, snapshot capture and drop counting.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        regs_d       = regs_q;
        csum_d       = csum_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        // A trigger seen while busy (including the final-accept cycle) is a drop.
        if (trig && busy_q) begin
            if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (trig) begin
                    pc_d       = pc;
                    instr_d    = instr;
                    regs_d     = regs_flat;
                    csum_d     = frame_checksum(pc, instr, regs_flat);
                    state_d    = SEND;
                    idx_d      = 4'd0;
                    tx_data_d  = HEADER;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    idx_d      = 4'd0;
                    tx_data_d  = 8'h00;
                    tx_valid_d = 1'b0;
                    busy_d     = 1'b0;
                end
            end
            SEND: begin
                if (accept_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        idx_d        = 4'd0;
                        tx_data_d    = 8'h00;
                        tx_valid_d   = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        tx_data_d = frame_byte(idx_q + 4'd1, pc_q, instr_q, regs_q, csum_q);
                    end
                end else begin
                    idx_d     = idx_q;
                    tx_data_d = tx_data_q;
                end
            end
            default: begin
                state_d    = IDLE;
                idx_d      = 4'd0;
                tx_data_d  = 8'h00;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            pc_q         <= 8'h00;
            instr_q      <= 16'h0000;
            regs_q       <= '0;
            csum_q       <= 8'h00;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            regs_q       <= regs_d;
            csum_q       <= csum_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Self-checking bench for cpu_state_dumper: directed frame table, corner-case
// sequences, and a randomized run scored against a queue-based frame model.
module tb_cpu_state_dumper;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [63:0] regs_flat;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    cpu_state_dumper dut (
        .clk        (clk),
        .reset      (reset),
        .trig       (trig),
        .pc         (pc),
        .instr      (instr),
        .regs_flat  (regs_flat),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [63:0] regs;
        logic [7:0]  csum;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] exp_byte(input vec_t v, input int b);
        logic [7:0] r;
        if (b == 0)       r = 8'hA5;
        else if (b == 1)  r = v.pc;
        else if (b == 2)  r = v.instr[15:8];
        else if (b == 3)  r = v.instr[7:0];
        else if (b <= 11) r = v.regs[8*(b-4) +: 8];
        else              r = v.csum;
        return r;
    endfunction

    // ---------------- reference model: queue of bytes still to send ----------
    logic [7:0] mq[$];
    bit         m_done = 1'b0;
    int         m_drop = 0;

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            mq.delete();
            m_done = 1'b0;
            m_drop = 0;
        end else begin
            m_done = 1'b0;
            if (mq.size() > 0) begin
                if (trig && m_drop < 255) m_drop = m_drop + 1;
                if (tx_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) m_done = 1'b1;
                end
            end else if (trig) begin
                logic [7:0] c;
                mq.push_back(8'hA5);
                mq.push_back(pc);
                mq.push_back(instr[15:8]);
                mq.push_back(instr[7:0]);
                for (int k = 0; k < 8; k++) mq.push_back(regs_flat[8*k +: 8]);
                c = 8'h00;
                foreach (mq[k]) c = c ^ mq[k];
                mq.push_back(c);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", tx_valid, (mq.size() > 0));
            chk("m_busy",  busy,     (mq.size() > 0));
            chk("m_data",  tx_data,  (mq.size() > 0) ? mq[0] : 8'h00);
            chk("m_done",  frame_done, m_done);
            chk("m_drop",  drop_cnt, m_drop);
        end
    end

    // -------------------------------------------------------------------------
    task automatic set_vec(input vec_t v);
        pc        = v.pc;
        instr     = v.instr;
        regs_flat = v.regs;
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    // Expects the frame to be on offer; drains it with tx_ready held high.
    task automatic run_frame(input vec_t v, input string tag);
        tx_ready = 1'b1;
        for (int b = 0; b < 13; b++) begin
            chk({tag, "_valid"}, tx_valid, 1'b1);
            chk({tag, "_byte"}, tx_data, exp_byte(v, b));
            tick();
        end
        chk({tag, "_fdone"}, frame_done, 1'b1);
        chk({tag, "_vlow"}, tx_valid, 1'b0);
        chk({tag, "_dzero"}, tx_data, 8'h00);
        tick();
        chk({tag, "_fdone1"}, frame_done, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] got[$];
        logic [7:0] prev_data;
        bit         prev_stall;
        int         c;

        tbl[0] = '{8'h03, 16'h1234, 64'h0706050403020100, 8'h80};
        tbl[1] = '{8'h00, 16'h0000, 64'h0000000000000000, 8'hA5};
        tbl[2] = '{8'hFF, 16'hFFFF, 64'hFFFFFFFFFFFFFFFF, 8'h5A};
        tbl[3] = '{8'h5A, 16'hA55A, 64'h0000000000000000, 8'h00};
        tbl[4] = '{8'h01, 16'h0000, 64'h0000000000000080, 8'h24};

        reset = 1'b0; trig = 1'b0; tx_ready = 1'b1;
        set_vec(tbl[0]);
        tick();
        tick();
        chk_en = 1'b1;
        chk("rst_valid", tx_valid, 1'b0);
        chk("rst_data",  tx_data,  8'h00);
        chk("rst_busy",  busy,     1'b0);
        chk("rst_fdone", frame_done, 1'b0);
        chk("rst_drop",  drop_cnt, 8'h00);
        reset = 1'b1;
        tick();

        // Table of frames, ready held high.
        for (int i = 0; i < 5; i++) begin
            set_vec(tbl[i]);
            pulse_trig();
            run_frame(tbl[i], "tbl");
        end

        // Backpressure with ready pattern 1,0,0 repeating.
        set_vec(tbl[0]);
        pulse_trig();
        c = 0; prev_stall = 1'b0; prev_data = 8'h00;
        while (got.size() < 13 && c < 100) begin
            tx_ready = (c % 3 == 0);
            chk("bp_valid", tx_valid, 1'b1);
            if (prev_stall) chk("bp_stable", tx_data, prev_data);
            if (tx_ready) got.push_back(tx_data);
            prev_stall = !tx_ready;
            prev_data  = tx_data;
            tick();
            c++;
        end
        chk("bp_count", got.size(), 13);
        chk("bp_fdone", frame_done, 1'b1);
        foreach (got[k]) chk("bp_byte", got[k], exp_byte(tbl[0], k));
        tx_ready = 1'b1;
        tick();

        // Snapshot isolation: live inputs change right after the trigger.
        set_vec(tbl[0]);
        pulse_trig();
        pc = 8'hFF;
        regs_flat[31:24] = 8'hAA;
        instr = 16'hBEEF;
        run_frame(tbl[0], "snap");

        // Drops: three mid-frame, one on the final accept, then restart in frame_done cycle.
        reset = 1'b0; tick(); reset = 1'b1;
        set_vec(tbl[0]);
        pulse_trig();
        for (int k = 0; k < 13; k++) begin
            trig = (k == 2 || k == 5 || k == 8 || k == 12);
            tick();
        end
        chk("drop_fdone", frame_done, 1'b1);
        chk("drop_cnt4", drop_cnt, 8'd4);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("drop_restart_v", tx_valid, 1'b1);
        chk("drop_restart_d", tx_data, 8'hA5);
        chk("drop_keep4", drop_cnt, 8'd4);
        run_frame(tbl[0], "drop2");

        // Reset abort at idx5.
        pulse_trig();
        for (int k = 0; k < 5; k++) tick();
        chk("abort_idx5", tx_data, exp_byte(tbl[0], 5));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_valid", tx_valid, 1'b0);
        chk("abort_busy",  busy,     1'b0);
        chk("abort_drop",  drop_cnt, 8'h00);
        chk("abort_fdone", frame_done, 1'b0);
        tick();
        chk("abort_fdone2", frame_done, 1'b0);
        pulse_trig();
        run_frame(tbl[0], "abort_new");

        // Saturation: 300 trigger cycles while stalled.
        tx_ready = 1'b0;
        pulse_trig();
        trig = 1'b1;
        for (int k = 0; k < 300; k++) tick();
        trig = 1'b0;
        chk("sat_cnt",  drop_cnt, 8'd255);
        chk("sat_data", tx_data,  8'hA5);
        tx_ready = 1'b1;
        for (int k = 0; k < 14; k++) tick();
        chk("sat_idle", busy, 1'b0);
        chk("sat_hold", drop_cnt, 8'd255);

        // Randomized traffic against the model.
        reset = 1'b0; tick(); reset = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            trig      = ($urandom_range(7) == 0);
            tx_ready  = ($urandom_range(3) != 0);
            reset     = ($urandom_range(299) != 0);
            pc        = 8'($urandom);
            instr     = 16'($urandom);
            regs_flat = {$urandom, $urandom};
            tick();
        end
        reset = 1'b1; trig = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
